// File: rtl/ac_channel_fifo.sv
// Synchronous FIFO for one ac_channel link between HLS kernels (any DEPTH >= 1).
// Optional statistics ports (level, overflow, underflow) are enabled by CHANNEL_FIFO_STATS_EN.
module ac_channel_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chan_rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             write_valid,
  output logic             write_ready,
  input  logic             read_valid,
  output logic             read_ready,
  output logic [WIDTH-1:0] out_data
`ifdef CHANNEL_FIFO_STATS_EN
  ,
  output logic [AW-1:0]    level,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr_next;
  logic [PW-1:0]    rd_ptr_next;
  logic [AW-1:0]    count;
  logic             clear;
  logic             push;
  logic             pop;

  assign clear = rst | chan_rst;

  // Handshakes come only from registered count, so a same-cycle pop never frees a slot for a push.
  assign write_ready = (count != AW'(DEPTH));
  assign read_ready  = (count != '0);

  assign push = write_valid & write_ready & ~clear;
  assign pop  = read_valid & read_ready & ~clear;

  always_comb begin
    wr_ptr_next = wr_ptr + PW'(1);
    rd_ptr_next = rd_ptr + PW'(1);
    if (wr_ptr == PW'(DEPTH - 1)) wr_ptr_next = '0;
    if (rd_ptr == PW'(DEPTH - 1)) rd_ptr_next = '0;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr_next;
      if (pop) begin
        rd_ptr   <= rd_ptr_next;
        out_data <= mem[rd_ptr];
      end
      if (push && !pop) count <= count + AW'(1);
      else if (pop && !push) count <= count - AW'(1);
    end
  end

  // Storage is never reset; stale words are unreachable because the pointers restart at zero.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef CHANNEL_FIFO_STATS_EN
  assign level = count;

  always_ff @(posedge clk) begin
    if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (write_valid && !write_ready) overflow <= 1'b1;
      if (read_valid && !read_ready) underflow <= 1'b1;
    end
  end
`endif

endmodule
